// File: rtl/alu_pkg.sv
// Shared opcode and FSM state encodings for seq_alu and its MUL/DIV datapath.
// Optional flag outputs of seq_alu are enabled with `define ALU_FLAGS_EN.
package alu_pkg;

  localparam logic [3:0] OP_ADD = 4'd0;
  localparam logic [3:0] OP_SUB = 4'd1;
  localparam logic [3:0] OP_AND = 4'd2;
  localparam logic [3:0] OP_OR  = 4'd3;
  localparam logic [3:0] OP_XOR = 4'd4;
  localparam logic [3:0] OP_SHL = 4'd5;
  localparam logic [3:0] OP_SHR = 4'd6;
  localparam logic [3:0] OP_MUL = 4'd7;
  localparam logic [3:0] OP_DIV = 4'd8;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_BUSY = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  // Shift amount uses r2[log2(WIDTH):0], i.e. log2(WIDTH)+1 bits.
  function automatic int unsigned shamt_width(input int unsigned w);
    return $clog2(w) + 1;
  endfunction

endpackage

// File: rtl/seq_alu_muldiv.sv
// Iterative datapath: shift-add multiply and restoring divide, one step per cycle.
// Result outputs carry the post-step value so the caller can register them on the done cycle.
module seq_alu_muldiv #(
  parameter int unsigned WIDTH = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               is_div,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] product,
  output logic [WIDTH-1:0]   quotient,
  output logic [WIDTH-1:0]   remainder
);

  localparam int unsigned CW = $clog2(WIDTH);
  localparam logic [CW-1:0] CNT_INIT = CW'(WIDTH - 1);

  logic               busy_q, busy_d;
  logic               is_div_q, is_div_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [2*WIDTH-1:0] mcand_q, mcand_d;
  logic [WIDTH-1:0]   mplier_q, mplier_d;
  logic [WIDTH-1:0]   rem_q, rem_d;
  logic [WIDTH-1:0]   quo_q, quo_d;
  logic [WIDTH-1:0]   divisor_q, divisor_d;
  logic [WIDTH:0]     shifted;
  logic [WIDTH:0]     trial;

  always_comb begin
    busy_d    = busy_q;
    is_div_d  = is_div_q;
    cnt_d     = cnt_q;
    acc_d     = acc_q;
    mcand_d   = mcand_q;
    mplier_d  = mplier_q;
    rem_d     = rem_q;
    quo_d     = quo_q;
    divisor_d = divisor_q;
    // Restoring step: bring the next dividend bit into the partial remainder.
    shifted   = {rem_q, quo_q[WIDTH-1]};
    trial     = shifted - {1'b0, divisor_q};
    if (start) begin
      busy_d    = 1'b1;
      is_div_d  = is_div;
      cnt_d     = CNT_INIT;
      acc_d     = '0;
      mcand_d   = {{WIDTH{1'b0}}, a};
      mplier_d  = b;
      rem_d     = '0;
      quo_d     = a;
      divisor_d = b;
    end else if (busy_q) begin
      if (is_div_q) begin
        if (shifted >= {1'b0, divisor_q}) begin
          rem_d = trial[WIDTH-1:0];
          quo_d = {quo_q[WIDTH-2:0], 1'b1};
        end else begin
          rem_d = shifted[WIDTH-1:0];
          quo_d = {quo_q[WIDTH-2:0], 1'b0};
        end
      end else begin
        if (mplier_q[0]) acc_d = acc_q + mcand_q;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
      end
      if (cnt_q == '0) busy_d = 1'b0;
      else             cnt_d  = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      busy_q    <= 1'b0;
      is_div_q  <= 1'b0;
      cnt_q     <= '0;
      acc_q     <= '0;
      mcand_q   <= '0;
      mplier_q  <= '0;
      rem_q     <= '0;
      quo_q     <= '0;
      divisor_q <= '0;
    end else begin
      busy_q    <= busy_d;
      is_div_q  <= is_div_d;
      cnt_q     <= cnt_d;
      acc_q     <= acc_d;
      mcand_q   <= mcand_d;
      mplier_q  <= mplier_d;
      rem_q     <= rem_d;
      quo_q     <= quo_d;
      divisor_q <= divisor_d;
    end
  end

  assign busy      = busy_q;
  assign done      = busy_q && (cnt_q == '0);
  assign product   = acc_d;
  assign quotient  = quo_d;
  assign remainder = rem_d;

endmodule

// File: rtl/seq_alu.sv
// Registered ALU with valid/ready handshake; MUL/DIV run iteratively in seq_alu_muldiv.
// `define ALU_FLAGS_EN to add registered flag_z/flag_c/flag_v outputs.
module seq_alu
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   r1,
  input  logic [WIDTH-1:0]   r2,
  input  logic [3:0]         op_code,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] out,
  output logic               err
`ifdef ALU_FLAGS_EN
  ,
  output logic               flag_z,
  output logic               flag_c,
  output logic               flag_v
`endif
);

  localparam int unsigned OW  = 2 * WIDTH;
  localparam int unsigned SHW = shamt_width(WIDTH);

  logic [1:0]         state_q, state_d;
  logic [OW-1:0]      out_q, out_d;
  logic               err_q, err_d;
  logic               is_div_q, is_div_d;
  logic [OW-1:0]      a_ext, b_ext;
  logic [WIDTH:0]     sum;
  logic [SHW-1:0]     shamt;
  logic               md_start, md_busy, md_done;
  logic [OW-1:0]      md_prod;
  logic [WIDTH-1:0]   md_quo, md_rem;

`ifdef ALU_FLAGS_EN
  logic               flag_z_q, flag_z_d;
  logic               flag_c_q, flag_c_d;
  logic               flag_v_q, flag_v_d;
  logic [WIDTH-1:0]   diff_w;
  assign diff_w = r1 - r2;
`endif

  assign a_ext = {{WIDTH{1'b0}}, r1};
  assign b_ext = {{WIDTH{1'b0}}, r2};
  assign sum   = {1'b0, r1} + {1'b0, r2};
  assign shamt = r2[SHW-1:0];

  // Division by zero is resolved immediately and never starts the datapath.
  assign md_start = in_valid && (state_q == ST_IDLE) &&
                    ((op_code == OP_MUL) || ((op_code == OP_DIV) && (r2 != '0)));

  seq_alu_muldiv #(
    .WIDTH(WIDTH)
  ) u_muldiv (
    .clk       (clk),
    .rst       (rst),
    .start     (md_start),
    .is_div    (op_code == OP_DIV),
    .a         (r1),
    .b         (r2),
    .busy      (md_busy),
    .done      (md_done),
    .product   (md_prod),
    .quotient  (md_quo),
    .remainder (md_rem)
  );

  always_comb begin
    state_d  = state_q;
    out_d    = out_q;
    err_d    = err_q;
    is_div_d = is_div_q;
`ifdef ALU_FLAGS_EN
    flag_z_d = flag_z_q;
    flag_c_d = flag_c_q;
    flag_v_d = flag_v_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          state_d = ST_DONE;
          err_d   = 1'b0;
`ifdef ALU_FLAGS_EN
          flag_c_d = 1'b0;
          flag_v_d = 1'b0;
`endif
          case (op_code)
            OP_ADD: begin
              out_d = {{(WIDTH-1){1'b0}}, sum};
`ifdef ALU_FLAGS_EN
              flag_c_d = sum[WIDTH];
              flag_v_d = (r1[WIDTH-1] == r2[WIDTH-1]) && (sum[WIDTH-1] != r1[WIDTH-1]);
`endif
            end
            OP_SUB: begin
              out_d = a_ext - b_ext;
`ifdef ALU_FLAGS_EN
              flag_c_d = (r1 < r2);
              flag_v_d = (r1[WIDTH-1] != r2[WIDTH-1]) && (diff_w[WIDTH-1] != r1[WIDTH-1]);
`endif
            end
            OP_AND: out_d = a_ext & b_ext;
            OP_OR:  out_d = a_ext | b_ext;
            OP_XOR: out_d = a_ext ^ b_ext;
            OP_SHL: out_d = (32'(shamt) >= OW) ? '0 : (a_ext << shamt);
            OP_SHR: out_d = (32'(shamt) >= OW) ? '0 : (a_ext >> shamt);
            OP_MUL: begin
              is_div_d = 1'b0;
              state_d  = ST_BUSY;
            end
            OP_DIV: begin
              if (r2 == '0) begin
                out_d = {r1, {WIDTH{1'b1}}};
                err_d = 1'b1;
              end else begin
                is_div_d = 1'b1;
                state_d  = ST_BUSY;
              end
            end
            default: begin
              out_d = '0;
              err_d = 1'b1;
            end
          endcase
        end
      end
      ST_BUSY: begin
        if (md_busy && md_done) begin
          state_d = ST_DONE;
          err_d   = 1'b0;
          out_d   = is_div_q ? {md_rem, md_quo} : md_prod;
`ifdef ALU_FLAGS_EN
          flag_c_d = 1'b0;
          flag_v_d = 1'b0;
`endif
        end
      end
      ST_DONE: begin
        if (out_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
`ifdef ALU_FLAGS_EN
    if ((state_d == ST_DONE) && (state_q != ST_DONE)) flag_z_d = (out_d == '0);
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      out_q    <= '0;
      err_q    <= 1'b0;
      is_div_q <= 1'b0;
`ifdef ALU_FLAGS_EN
      flag_z_q <= 1'b0;
      flag_c_q <= 1'b0;
      flag_v_q <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      out_q    <= out_d;
      err_q    <= err_d;
      is_div_q <= is_div_d;
`ifdef ALU_FLAGS_EN
      flag_z_q <= flag_z_d;
      flag_c_q <= flag_c_d;
      flag_v_q <= flag_v_d;
`endif
    end
  end

  assign in_ready  = (state_q == ST_IDLE);
  assign out_valid = (state_q == ST_DONE);
  assign out       = out_q;
  assign err       = err_q;
`ifdef ALU_FLAGS_EN
  assign flag_z = flag_z_q;
  assign flag_c = flag_c_q;
  assign flag_v = flag_v_q;
`endif

endmodule

// File: tb/tb_seq_alu.sv
// Bench for seq_alu (WIDTH=4): arithmetic reference model plus directed literal checks.
// Flag checks are included when ALU_FLAGS_EN is defined.
module tb_seq_alu;

  logic       clk;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [3:0] r1;
  logic [3:0] r2;
  logic [3:0] op_code;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out;
  logic       err;
`ifdef ALU_FLAGS_EN
  logic       flag_z, flag_c, flag_v;
`endif

  seq_alu #(.WIDTH(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .r1        (r1),
    .r2        (r2),
    .op_code   (op_code),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out       (out),
    .err       (err)
`ifdef ALU_FLAGS_EN
    ,
    .flag_z    (flag_z),
    .flag_c    (flag_c),
    .flag_v    (flag_v)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  typedef struct packed {
    logic [7:0] o;
    logic       e;
    logic       z;
    logic       c;
    logic       v;
    logic [3:0] lat;
  } exp_t;

  function automatic int as_signed4(input int x);
    return (x >= 8) ? x - 16 : x;
  endfunction

  // Reference: plain integer arithmetic on the opcode definitions.
  function automatic exp_t ref_op(input logic [3:0] op, input logic [3:0] a, input logic [3:0] b);
    exp_t x;
    int ia, ib, r, s;
    ia = int'(a);
    ib = int'(b);
    r = 0;
    x = '0;
    x.lat = 4'd1;
    case (int'(op))
      0: begin
        r = ia + ib;
        x.c = (r > 15);
        s = as_signed4(ia) + as_signed4(ib);
        x.v = (s > 7) || (s < -8);
      end
      1: begin
        r = (ia - ib) & 255;
        x.c = (ia < ib);
        s = as_signed4(ia) - as_signed4(ib);
        x.v = (s > 7) || (s < -8);
      end
      2: r = ia & ib;
      3: r = ia | ib;
      4: r = ia ^ ib;
      5: r = ((ib % 8) >= 8) ? 0 : ((ia << (ib % 8)) & 255);
      6: r = ia >> (ib % 8);
      7: begin
        r = ia * ib;
        x.lat = 4'd5;
      end
      8: begin
        if (ib == 0) begin
          r = ia * 16 + 15;
          x.e = 1'b1;
        end else begin
          r = (ia % ib) * 16 + (ia / ib);
          x.lat = 4'd5;
        end
      end
      default: x.e = 1'b1;
    endcase
    x.o = r[7:0];
    x.z = (x.o == 8'h00);
    return x;
  endfunction

  bit   started  = 1'b0;
  bit   inflight = 1'b0;
  bit   post_rst = 1'b0;
  int   age      = 0;
  exp_t m        = '0;

  always @(posedge clk) begin
    if (rst) begin
      started  <= 1'b1;
      inflight <= 1'b0;
      post_rst <= 1'b1;
    end else if (!inflight) begin
      if (in_valid) begin
        m        <= ref_op(op_code, r1, r2);
        inflight <= 1'b1;
        age      <= 1;
        post_rst <= 1'b0;
      end
    end else if ((age >= int'(m.lat)) && out_ready) begin
      inflight <= 1'b0;
    end else begin
      age <= age + 1;
    end
  end

  always @(negedge clk) begin
    if (started) begin
      chk("in_ready", {31'd0, in_ready}, {31'd0, !inflight});
      chk("out_valid", {31'd0, out_valid}, {31'd0, inflight && (age >= int'(m.lat))});
      if (inflight && (age >= int'(m.lat))) begin
        chk("out", {24'd0, out}, {24'd0, m.o});
        chk("err", {31'd0, err}, {31'd0, m.e});
`ifdef ALU_FLAGS_EN
        chk("flag_z", {31'd0, flag_z}, {31'd0, m.z});
        chk("flag_c", {31'd0, flag_c}, {31'd0, m.c});
        chk("flag_v", {31'd0, flag_v}, {31'd0, m.v});
`endif
      end else if (post_rst && !inflight) begin
        chk("rst_out", {24'd0, out}, 32'd0);
        chk("rst_err", {31'd0, err}, 32'd0);
      end
    end
  end

  task automatic run_op(input logic [3:0] op, input logic [3:0] a, input logic [3:0] b,
                        input logic [7:0] eo, input logic ee, input int el, input int hold,
                        input logic ec, input logic ev);
    int n;
    n = 0;
    while (inflight && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    op_code = op; r1 = a; r2 = b; in_valid = 1'b1; out_ready = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b0;
    r1 = 4'($urandom); r2 = 4'($urandom); op_code = 4'($urandom);
    n = 1;
    while (!out_valid && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    chk("lit_valid", {31'd0, out_valid}, 32'd1);
    chk("lit_latency", n, el);
    chk("lit_out", {24'd0, out}, {24'd0, eo});
    chk("lit_err", {31'd0, err}, {31'd0, ee});
`ifdef ALU_FLAGS_EN
    chk("lit_flag_c", {31'd0, flag_c}, {31'd0, ec});
    chk("lit_flag_v", {31'd0, flag_v}, {31'd0, ev});
`else
    if (ec === 1'bx || ev === 1'bx) $display("flag arguments unknown");
`endif
    for (int i = 0; i < hold; i++) begin
      in_valid = 1'b1;
      op_code = 4'($urandom_range(0, 6)); r1 = 4'($urandom); r2 = 4'($urandom);
      @(posedge clk); #1;
      chk("hold_valid", {31'd0, out_valid}, 32'd1);
      chk("hold_out", {24'd0, out}, {24'd0, eo});
      chk("hold_ready", {31'd0, in_ready}, 32'd0);
    end
    in_valid = 1'b0; out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: actual=running required=finished");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    r1 = '0; r2 = '0; op_code = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    chk("reset_in_ready", {31'd0, in_ready}, 32'd1);
    chk("reset_out_valid", {31'd0, out_valid}, 32'd0);
    chk("reset_out", {24'd0, out}, 32'd0);
    chk("reset_err", {31'd0, err}, 32'd0);

    run_op(4'd0, 4'b0111, 4'b0100, 8'h0B, 1'b0, 1, 0, 1'b0, 1'b1);
    run_op(4'd1, 4'b1010, 4'b0001, 8'h09, 1'b0, 1, 0, 1'b0, 1'b0);
    run_op(4'd7, 4'b1111, 4'b1111, 8'hE1, 1'b0, 5, 0, 1'b0, 1'b0);
    run_op(4'd8, 4'b1101, 4'b0100, 8'h13, 1'b0, 5, 0, 1'b0, 1'b0);
    run_op(4'd8, 4'b1001, 4'b0000, 8'h9F, 1'b1, 1, 0, 1'b0, 1'b0);
    run_op(4'd0, 4'b0011, 4'b0011, 8'h06, 1'b0, 1, 10, 1'b0, 1'b0);
    run_op(4'd15, 4'b0101, 4'b0011, 8'h00, 1'b1, 1, 0, 1'b0, 1'b0);
    run_op(4'd5, 4'b1011, 4'b0111, 8'h80, 1'b0, 1, 0, 1'b0, 1'b0);
    run_op(4'd0, 4'b0111, 4'b0001, 8'h08, 1'b0, 1, 0, 1'b0, 1'b1);
    run_op(4'd1, 4'b0000, 4'b0001, 8'hFF, 1'b0, 1, 0, 1'b1, 1'b0);

    // Reset on the second BUSY cycle of a multiply.
    op_code = 4'd7; r1 = 4'd9; r2 = 4'd6; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("midbusy_rst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("midbusy_rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("midbusy_rst_out", {24'd0, out}, 32'd0);
    run_op(4'd0, 4'b0001, 4'b0001, 8'h02, 1'b0, 1, 0, 1'b0, 1'b0);

    for (int cyc = 0; cyc < 3000; cyc++) begin
      in_valid  = ($urandom_range(0, 2) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      op_code   = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'($urandom_range(0, 8));
      r1        = 4'($urandom);
      r2        = ($urandom_range(0, 7) == 0) ? 4'd0 : 4'($urandom);
      rst       = ($urandom_range(0, 249) == 0);
      @(posedge clk); #1;
    end
    rst = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    repeat (8) @(posedge clk);
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
